// File: rtl/riscuin_bus_pkg.sv
// rtl/riscuin_bus_pkg.sv - shared access-size and FSM state encodings plus byte-lane helpers
package riscuin_bus_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10,
    SIZE_X = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    FAULT  = 2'd3
  } state_e;

  function automatic logic [3:0] lane_be(input size_e sz, input logic [1:0] lo);
    case (sz)
      SIZE_B:  lane_be = 4'b0001 << lo;
      SIZE_H:  lane_be = lo[1] ? 4'b1100 : 4'b0011;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  // Right-aligned write data is replicated so every candidate lane carries it.
  function automatic logic [31:0] lane_wdata(input size_e sz, input logic [31:0] d);
    case (sz)
      SIZE_B:  lane_wdata = {4{d[7:0]}};
      SIZE_H:  lane_wdata = {2{d[15:0]}};
      default: lane_wdata = d;
    endcase
  endfunction

  function automatic logic [31:0] lane_rdata(input size_e sz, input logic [1:0] lo,
                                             input logic [31:0] w);
    logic [31:0] sh;
    sh = w >> {lo, 3'b000};
    case (sz)
      SIZE_B:  lane_rdata = {24'd0, sh[7:0]};
      SIZE_H:  lane_rdata = {16'd0, sh[15:0]};
      default: lane_rdata = w;
    endcase
  endfunction

endpackage

// File: rtl/data_ram.sv
// rtl/data_ram.sv - 32-bit word RAM with per-byte write enables and combinational read
module data_ram #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [3:0]            i_be,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [31:0]           i_wdata,
  output logic [31:0]           o_rdata
);

  logic [31:0] r_mem [0:(1<<ADDR_WIDTH)-1];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int i = 0; i < 4; i++) begin
        if (i_be[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/data_bus_responder.sv
// rtl/data_bus_responder.sv - core data-bus slave: validates requests, inserts wait states, accesses data_ram
module data_bus_responder
  import riscuin_bus_pkg::*;
#(
  parameter int DATA_ADDR_WIDTH = 10,
  parameter int WAIT_STATES     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wd,
  input  logic        rd,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic        fault
);

  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_e                     r_state, w_next;
  logic                       r_armed;
  logic [3:0]                 r_cnt;
  logic                       r_wr;
  size_e                      r_size;
  logic [1:0]                 r_lo;
  logic [DATA_ADDR_WIDTH-1:0] r_word;
  logic [31:0]                r_din;
  logic [31:0]                r_dout;

  size_e       w_size;
  logic        w_req, w_bad, w_oor, w_we;
  logic [31:0] w_ram_q, w_rd_lanes;

  assign w_size = size_e'(size);
  // r_armed keeps ready low until the first edge after reset is released.
  assign w_req  = r_armed && (r_state == IDLE) && (wd || rd);
  assign w_oor  = (addr[31:2] >> DATA_ADDR_WIDTH) != 30'd0;
  assign w_bad  = (wd && rd) || (w_size == SIZE_X) ||
                  ((w_size == SIZE_H) && addr[0]) ||
                  ((w_size == SIZE_W) && (addr[1:0] != 2'b00)) || w_oor;
  assign w_we   = (r_state == ACCESS) && r_wr && rst;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_req) w_next = w_bad ? FAULT : ((WAIT_STATES > 0) ? WAIT : ACCESS);
      WAIT:    if (r_cnt == 4'd0) w_next = ACCESS;
      ACCESS:  w_next = IDLE;
      FAULT:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    ready    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    fault    = 1'b0;
    data_out = r_dout;
    case (r_state)
      IDLE:    ready = r_armed;
      WAIT:    busy = 1'b1;
      ACCESS: begin
        done = 1'b1;
        if (!r_wr) data_out = w_rd_lanes;
      end
      FAULT:   fault = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_armed <= 1'b0;
      r_cnt   <= 4'd0;
      r_wr    <= 1'b0;
      r_size  <= SIZE_B;
      r_lo    <= 2'b00;
      r_word  <= '0;
      r_din   <= 32'd0;
      r_dout  <= 32'd0;
    end else begin
      r_armed <= 1'b1;
      if (w_req) begin
        r_wr   <= wd;
        r_size <= w_size;
        r_lo   <= addr[1:0];
        r_word <= addr[DATA_ADDR_WIDTH+1:2];
        r_din  <= data_in;
        r_cnt  <= CNT_INIT;
      end else if ((r_state == WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if ((r_state == ACCESS) && !r_wr) r_dout <= w_rd_lanes;
    end
  end

  assign w_rd_lanes = lane_rdata(r_size, r_lo, w_ram_q);

  data_ram #(.ADDR_WIDTH(DATA_ADDR_WIDTH)) u_ram (
    .i_clk   (clk),
    .i_we    (w_we),
    .i_be    (lane_be(r_size, r_lo)),
    .i_addr  (r_word),
    .i_wdata (lane_wdata(r_size, r_din)),
    .o_rdata (w_ram_q)
  );

endmodule

// File: tb/tb_data_bus_responder.sv
// tb/tb_data_bus_responder.sv - scoreboard bench for data_bus_responder (WAIT_STATES=1 and 3)
module tb_data_bus_responder;

  localparam int WS0 = 1;
  localparam int WS1 = 3;
  localparam logic [1:0] SB = 2'b00, SH = 2'b01, SW = 2'b10, SX = 2'b11;

  typedef struct {
    int          dut;
    bit          flt;
    logic [31:0] dout;
    int          lat;
    int          req_cyc;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_v [2];
  logic        wd_v [2];
  logic        rd_v [2];
  logic        ready_v [2];
  logic        busy_v [2];
  logic        done_v [2];
  logic        fault_v [2];
  logic [31:0] dout_v [2];
  logic [1:0]  size_b;
  logic [31:0] addr_b, din_b;
  logic [31:0] last_rd [2];

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t exp_q [$];
  exp_t e_mon;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_bus_responder #(.DATA_ADDR_WIDTH(10), .WAIT_STATES(WS0)) u_dut0 (
    .clk(clk), .rst(rst_v[0]), .wd(wd_v[0]), .rd(rd_v[0]), .size(size_b), .addr(addr_b),
    .data_in(din_b), .data_out(dout_v[0]), .ready(ready_v[0]), .busy(busy_v[0]),
    .done(done_v[0]), .fault(fault_v[0])
  );

  data_bus_responder #(.DATA_ADDR_WIDTH(4), .WAIT_STATES(WS1)) u_dut1 (
    .clk(clk), .rst(rst_v[1]), .wd(wd_v[1]), .rd(rd_v[1]), .size(size_b), .addr(addr_b),
    .data_in(din_b), .data_out(dout_v[1]), .ready(ready_v[1]), .busy(busy_v[1]),
    .done(done_v[1]), .fault(fault_v[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int ws_of(input int d);
    return (d == 0) ? WS0 : WS1;
  endfunction

  // Monitor: every done/fault pulse consumes one expectation.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (done_v[d] === 1'b1 || fault_v[d] === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_completion_dut%0d: got done=%b fault=%b expected none",
                   d, done_v[d], fault_v[d]);
        end else begin
          e_mon = exp_q.pop_front();
          check({e_mon.name, "_dut"}, d, e_mon.dut);
          check({e_mon.name, "_fault"}, {31'b0, fault_v[d]}, {31'b0, e_mon.flt});
          check({e_mon.name, "_done"}, {31'b0, done_v[d]}, {31'b0, ~e_mon.flt});
          check({e_mon.name, "_data_out"}, dout_v[d], e_mon.dout);
          check({e_mon.name, "_latency"}, cyc - e_mon.req_cyc, e_mon.lat);
        end
      end
    end
  end

  task automatic start_req(input int d, input bit w, input bit r, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] din, input bit flt,
                           input logic [31:0] rdata, input string name, input bit push);
    exp_t e;
    for (int i = 0; i < 20 && ready_v[d] !== 1'b1; i++) @(negedge clk);
    check({name, "_ready_before"}, {31'b0, ready_v[d]}, 32'd1);
    wd_v[d] = w; rd_v[d] = r; size_b = sz; addr_b = a; din_b = din;
    if (!flt && r && !w) last_rd[d] = rdata;
    e.dut = d; e.flt = flt; e.dout = last_rd[d]; e.req_cyc = cyc;
    e.lat = flt ? 1 : ws_of(d) + 1; e.name = name;
    if (push) exp_q.push_back(e);
    @(posedge clk);
    #1;
    wd_v[d] = 1'b0; rd_v[d] = 1'b0; size_b = ~sz; addr_b = ~a; din_b = ~din;
  endtask

  task automatic finish_req(input int d, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      seen = (done_v[d] === 1'b1) || (fault_v[d] === 1'b1);
    end
    check({name, "_completed"}, {31'b0, seen}, 32'd1);
    @(negedge clk);
    check({name, "_ready_after"}, {31'b0, ready_v[d]}, 32'd1);
  endtask

  task automatic issue(input int d, input bit w, input bit r, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] din, input bit flt,
                       input logic [31:0] rdata, input string name);
    start_req(d, w, r, sz, a, din, flt, rdata, name, 1'b1);
    finish_req(d, name);
  endtask

  task automatic check_reset_outs(input int d, input string name);
    check({name, "_ready"}, {31'b0, ready_v[d]}, 32'd0);
    check({name, "_busy"},  {31'b0, busy_v[d]},  32'd0);
    check({name, "_done"},  {31'b0, done_v[d]},  32'd0);
    check({name, "_fault"}, {31'b0, fault_v[d]}, 32'd0);
    check({name, "_data_out"}, dout_v[d], 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_v[d] = 1'b0; wd_v[d] = 1'b0; rd_v[d] = 1'b0; last_rd[d] = 32'd0;
    end
    size_b = SB; addr_b = 32'd0; din_b = 32'd0;
    repeat (2) @(negedge clk);
    check_reset_outs(0, "reset0");
    check_reset_outs(1, "reset1");
    rst_v[0] = 1'b1; rst_v[1] = 1'b1;
    check("ready_before_edge", {31'b0, ready_v[0]}, 32'd0);
    @(negedge clk);
    check("ready_first_edge0", {31'b0, ready_v[0]}, 32'd1);
    check("ready_first_edge1", {31'b0, ready_v[1]}, 32'd1);

    issue(0, 1, 0, SW, 32'h10, 32'hDEADBEEF, 0, 0, "wr_word");
    issue(0, 0, 1, SW, 32'h10, 0, 0, 32'hDEADBEEF, "rd_word");
    issue(0, 1, 0, SW, 32'h10, 32'h0, 0, 0, "wr_zero");
    issue(0, 1, 0, SB, 32'h13, 32'h123456A5, 0, 0, "wr_byte");
    issue(0, 0, 1, SW, 32'h10, 0, 0, 32'hA5000000, "rd_word_after_byte");
    issue(0, 0, 1, SB, 32'h13, 0, 0, 32'h000000A5, "rd_byte");
    issue(0, 0, 1, SH, 32'h11, 0, 1, 0, "rd_half_misaligned");
    issue(0, 1, 1, SW, 32'h10, 32'hFFFFFFFF, 1, 0, "wd_rd_both");
    issue(0, 1, 0, SX, 32'h10, 32'hFFFFFFFF, 1, 0, "wr_size_illegal");
    issue(0, 0, 1, SW, 32'h10, 0, 0, 32'hA5000000, "rd_after_faults");
    issue(0, 1, 0, SH, 32'h10, 32'hFFFF1234, 0, 0, "wr_half");
    issue(0, 0, 1, SH, 32'h10, 0, 0, 32'h00001234, "rd_half_lo");
    issue(0, 0, 1, SH, 32'h12, 0, 0, 32'h0000A500, "rd_half_hi");
    issue(0, 0, 1, SB, 32'h11, 0, 0, 32'h00000012, "rd_byte1");
    issue(0, 0, 1, SW, 32'h10, 0, 0, 32'hA5001234, "rd_word_merged");
    issue(0, 1, 0, SW, 32'h12, 32'h0, 1, 0, "wr_word_misaligned");
    issue(0, 0, 1, SW, 32'h1000, 0, 1, 0, "rd_out_of_range");
    issue(0, 1, 0, SW, 32'hFFC, 32'h11223344, 0, 0, "wr_top_word");
    issue(0, 0, 1, SW, 32'hFFC, 0, 0, 32'h11223344, "rd_top_word");
    issue(0, 0, 1, SB, 32'hFFE, 0, 0, 32'h00000022, "rd_top_byte");

    // A read raised while a write is still waiting must be dropped.
    start_req(0, 1, 0, SW, 32'h40, 32'h55AA55AA, 0, 0, "wr_with_poke", 1'b1);
    @(negedge clk);
    check("poke_busy", {31'b0, busy_v[0]}, 32'd1);
    rd_v[0] = 1'b1; size_b = SW; addr_b = 32'h10;
    @(posedge clk);
    #1;
    rd_v[0] = 1'b0;
    finish_req(0, "wr_with_poke");
    repeat (4) @(negedge clk);
    issue(0, 0, 1, SW, 32'h40, 0, 0, 32'h55AA55AA, "rd_poked_word");

    issue(1, 1, 0, SW, 32'h20, 32'hCAFEF00D, 0, 0, "ws3_wr");
    issue(1, 0, 1, SW, 32'h20, 0, 0, 32'hCAFEF00D, "ws3_rd");
    issue(1, 0, 1, SW, 32'h40, 0, 1, 0, "ws3_out_of_range");
    issue(1, 1, 0, SW, 32'h3C, 32'h0F0F0F0F, 0, 0, "ws3_wr_top");
    issue(1, 0, 1, SW, 32'h3C, 0, 0, 32'h0F0F0F0F, "ws3_rd_top");

    start_req(1, 1, 0, SW, 32'h20, 32'h0BADBEEF, 0, 0, "ws3_abort", 1'b0);
    @(negedge clk);
    check("abort_busy", {31'b0, busy_v[1]}, 32'd1);
    rst_v[1] = 1'b0;
    @(negedge clk);
    check_reset_outs(1, "abort_reset");
    last_rd[1] = 32'd0;
    @(negedge clk);
    rst_v[1] = 1'b1;
    @(negedge clk);
    check("abort_ready_first_edge", {31'b0, ready_v[1]}, 32'd1);
    issue(1, 0, 1, SW, 32'h20, 0, 0, 32'hCAFEF00D, "ws3_rd_after_abort");

    repeat (4) @(negedge clk);
    check("pending_expectations", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
